datagram_link_tx: RTL and testbench

- Core-side transmitter of the core→display datagram link; the far end deserializes and drives each quadrant's renderer.
- Snapshots the full `MESSAGE_SIZE`-bit datagram (`{ingame_data, core_state}`) on request.
- Frames it as preamble, payload and CRC-8, and shifts it out over a narrow source-synchronous bus (clock, frame, data lanes).
- Counts requests lost while a frame is in flight.

---
 rtl/datagram_link_tx_pkg.sv | 34 +++
 rtl/datagram_link_tx_crc8_step.sv | 31 +++
 rtl/datagram_link_tx.sv | 248 ++++++++++++++++++++++++
 tb/tb_datagram_link_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datagram_link_tx_pkg.sv
// -----------------------------------------------------------------------------
// datagram_link_tx_pkg
// Shared definitions for the core->display datagram link. These are used by the
// transmitter and by the receiver on the display side.
//   - datagram field sizes and the total MESSAGE_SIZE
//   - link framing constants (preamble byte, CRC-8 polynomial)
//   - link state enum
//   - single-bit CRC-8 update helper
// -----------------------------------------------------------------------------
package datagram_link_tx_pkg;

    localparam int STATE_SIZE       = 4;
    localparam int INGAME_DATA_SIZE = 28;
    localparam int MESSAGE_SIZE     = INGAME_DATA_SIZE + STATE_SIZE;

    localparam logic [7:0] LINK_PREAMBLE = 8'hA5;
    localparam logic [7:0] LINK_CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        LTX_IDLE = 3'd0,
        LTX_PRE  = 3'd1,
        LTX_PAY  = 3'd2,
        LTX_CRC  = 3'd3,
        LTX_GAP  = 3'd4
    } link_tx_state_t;

    // One message bit into a CRC-8 (MSB-first, no reflection).
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? LINK_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/datagram_link_tx_crc8_step.sv
// -----------------------------------------------------------------------------
// crc8_step
// Combinational CRC-8 update over one LANES-bit beat. The MSB of the beat is
// taken first. Shared with the link receiver.
// Ports:
//   crc_in  [7:0]       running CRC before this beat
//   data    [LANES-1:0] beat bits
//   crc_out [7:0]       running CRC after this beat
// -----------------------------------------------------------------------------
module crc8_step
    import datagram_link_tx_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [7:0]       crc_in,
    input  logic [LANES-1:0] data,
    output logic [7:0]       crc_out
);

    logic [7:0] crc_v_s;

    // Unrolled bit-serial update, beat MSB first
    always_comb begin
        crc_v_s = crc_in;
        for (int i = LANES - 1; i >= 0; i--) begin
            crc_v_s = crc8_bit(crc_v_s, data[i]);
        end
        crc_out = crc_v_s;
    end

endmodule

// File: rtl/datagram_link_tx.sv
// -----------------------------------------------------------------------------
// datagram_link_tx
// Core-side transmitter of the core->display datagram link. On a request it
// snapshots the datagram and sends a frame over a narrow source-synchronous bus:
// the preamble byte, the payload (zero-padded at the LSB end to whole beats) and
// then a CRC-8 of the payload beats. A fixed idle gap follows each frame.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   datagram    payload, sampled only on acceptance
//   send_req    level-sensitive frame request
//   send_ack    pulse in the acceptance cycle
//   busy        frame or gap in progress
//   tx_sclk     link clock; the receiver samples on its rising edge
//   tx_frame    high during preamble, payload and CRC beats
//   tx_data     beat data, MSB-first
//   drop_count  saturating count of request rising edges seen while busy
// -----------------------------------------------------------------------------
module datagram_link_tx
    import datagram_link_tx_pkg::*;
#(
    parameter int         MSG_W     = MESSAGE_SIZE,
    parameter int         LANES     = 4,
    parameter int         CLK_DIV   = 4,
    parameter int         GAP_BEATS = 2,
    parameter logic [7:0] PREAMBLE  = LINK_PREAMBLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MSG_W-1:0] datagram,
    input  logic             send_req,
    output logic             send_ack,
    output logic             busy,
    output logic             tx_sclk,
    output logic             tx_frame,
    output logic [LANES-1:0] tx_data,
    output logic [7:0]       drop_count
);

    localparam int NB        = (MSG_W + LANES - 1) / LANES;
    localparam int PAY_W     = NB * LANES;
    localparam int SH_W      = 8 + PAY_W;
    localparam int SYM_BEATS = 8 / LANES;
    localparam int CNT_W     = $clog2(CLK_DIV);
    localparam int MAX_B0    = (NB > GAP_BEATS) ? NB : GAP_BEATS;
    localparam int MAX_B1    = (MAX_B0 > SYM_BEATS) ? MAX_B0 : SYM_BEATS;
    localparam int BEAT_W    = $clog2(MAX_B1 + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] SYM_LAST = BEAT_W'(SYM_BEATS - 1);
    localparam logic [BEAT_W-1:0] PAY_LAST = BEAT_W'(NB - 1);
    localparam logic [BEAT_W-1:0] GAP_LAST = BEAT_W'(GAP_BEATS - 1);

    link_tx_state_t    state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [BEAT_W-1:0] beat_r, beat_s;
    logic [SH_W-1:0]   sh_r, sh_s;
    logic [7:0]        crc_r, crc_s;
    logic [LANES-1:0]  data_r, data_s;
    logic              frame_r, frame_s;
    logic              sclk_r, sclk_s;
    logic              busy_r, busy_s;
    logic [7:0]        drop_r, drop_s;
    logic              req_d_r;

    logic [PAY_W-1:0]  pay_s;
    logic [SH_W-1:0]   load_s;
    logic [LANES-1:0]  sh_top_s;
    logic [7:0]        crc_step_s;
    logic              beat_end_s;
    logic              accept_s;

    // Frame image at acceptance: preamble followed by the LSB-padded payload
    always_comb begin
        pay_s                    = '0;
        pay_s[PAY_W-1 -: MSG_W]  = datagram;
        load_s                   = {PREAMBLE, pay_s};
    end

    assign sh_top_s   = sh_r[SH_W-1 -: LANES];
    assign beat_end_s = (cnt_r == CNT_LAST);

    crc8_step #(.LANES(LANES)) u_crc (
        .crc_in  (crc_r),
        .data    (sh_top_s),
        .crc_out (crc_step_s)
    );

    // Next-state and next-beat decode; beat outputs only change at count 0
    always_comb begin
        state_s  = state_r;
        beat_s   = beat_r;
        sh_s     = sh_r;
        crc_s    = crc_r;
        data_s   = data_r;
        frame_s  = frame_r;
        accept_s = 1'b0;
        case (state_r)
            LTX_IDLE: begin
                beat_s  = '0;
                data_s  = '0;
                frame_s = 1'b0;
                if (send_req) begin
                    accept_s = 1'b1;
                    state_s  = LTX_PRE;
                    data_s   = load_s[SH_W-1 -: LANES];
                    sh_s     = load_s << LANES;
                    crc_s    = 8'h00;
                    frame_s  = 1'b1;
                end else begin
                    state_s = LTX_IDLE;
                end
            end
            LTX_PRE: begin
                if (beat_end_s) begin
                    // The next beat comes from the shift register whether it is
                    // preamble or the first payload beat; only payload feeds CRC.
                    data_s = sh_top_s;
                    sh_s   = sh_r << LANES;
                    if (beat_r == SYM_LAST) begin
                        state_s = LTX_PAY;
                        beat_s  = '0;
                        crc_s   = crc_step_s;
                    end else begin
                        beat_s = beat_r + BEAT_ONE;
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            LTX_PAY: begin
                if (beat_end_s) begin
                    if (beat_r == PAY_LAST) begin
                        // crc_r already covers every payload beat here
                        state_s = LTX_CRC;
                        beat_s  = '0;
                        data_s  = crc_r[7 -: LANES];
                        crc_s   = crc_r << LANES;
                    end else begin
                        beat_s = beat_r + BEAT_ONE;
                        data_s = sh_top_s;
                        sh_s   = sh_r << LANES;
                        crc_s  = crc_step_s;
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            LTX_CRC: begin
                if (beat_end_s) begin
                    if (beat_r == SYM_LAST) begin
                        state_s = (GAP_BEATS == 0) ? LTX_IDLE : LTX_GAP;
                        beat_s  = '0;
                        data_s  = '0;
                        frame_s = 1'b0;
                    end else begin
                        beat_s = beat_r + BEAT_ONE;
                        data_s = crc_r[7 -: LANES];
                        crc_s  = crc_r << LANES;
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            LTX_GAP: begin
                data_s  = '0;
                frame_s = 1'b0;
                if (beat_end_s) begin
                    if (beat_r == GAP_LAST) begin
                        state_s = LTX_IDLE;
                        beat_s  = '0;
                    end else begin
                        beat_s = beat_r + BEAT_ONE;
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            default: begin
                state_s = LTX_IDLE;
                beat_s  = '0;
                data_s  = '0;
                frame_s = 1'b0;
            end
        endcase
    end

    // Beat phase counter and the link clock it produces; sclk held low in IDLE
    always_comb begin
        if ((state_s == LTX_IDLE) || (state_r == LTX_IDLE) || beat_end_s) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
        sclk_s = (state_s != LTX_IDLE) && (cnt_s >= CNT_HALF);
        busy_s = (state_s != LTX_IDLE);
    end

    // Saturating count of request rising edges that arrive while busy
    always_comb begin
        if (send_req && !req_d_r && busy_r && (drop_r != 8'hFF)) begin
            drop_s = drop_r + 8'd1;
        end else begin
            drop_s = drop_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LTX_IDLE;
            cnt_r   <= '0;
            beat_r  <= '0;
            sh_r    <= '0;
            crc_r   <= 8'h00;
            data_r  <= '0;
            frame_r <= 1'b0;
            sclk_r  <= 1'b0;
            busy_r  <= 1'b0;
            drop_r  <= 8'h00;
            req_d_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            beat_r  <= beat_s;
            sh_r    <= sh_s;
            crc_r   <= crc_s;
            data_r  <= data_s;
            frame_r <= frame_s;
            sclk_r  <= sclk_s;
            busy_r  <= busy_s;
            drop_r  <= drop_s;
            req_d_r <= send_req;
        end
    end

    // Acknowledge is combinational so it lands in the request cycle; reset wins
    assign send_ack   = accept_s & ~rst;
    assign busy       = busy_r;
    assign tx_sclk    = sclk_r;
    assign tx_frame   = frame_r;
    assign tx_data    = data_r;
    assign drop_count = drop_r;

endmodule

// File: tb/tb_datagram_link_tx.sv
// -----------------------------------------------------------------------------
// Testbench for datagram_link_tx. Two instances share clk/rst:
//   dut 0: MSG_W=12, LANES=4, CLK_DIV=2, GAP_BEATS=2
//   dut 1: MSG_W=10, LANES=4, CLK_DIV=4, GAP_BEATS=1 (two pad bits)
// Stimulus pushes expected frames into per-instance queues; a monitor per
// instance reassembles beats on tx_sclk rising edges and compares.
// -----------------------------------------------------------------------------
module tb_datagram_link_tx;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [1:0]  busy;
    logic [1:0]  sclk;
    logic [1:0]  frame;
    logic [11:0] dg   [2];
    logic [3:0]  data [2];
    logic [7:0]  drop [2];

    int checks;
    int errors;
    int drop_exp [2];

    logic [27:0] q0 [$];
    logic [27:0] q1 [$];

    datagram_link_tx #(.MSG_W(12), .LANES(4), .CLK_DIV(2), .GAP_BEATS(2), .PREAMBLE(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .datagram(dg[0]), .send_req(req[0]), .send_ack(ack[0]),
        .busy(busy[0]), .tx_sclk(sclk[0]), .tx_frame(frame[0]), .tx_data(data[0]),
        .drop_count(drop[0])
    );

    datagram_link_tx #(.MSG_W(10), .LANES(4), .CLK_DIV(4), .GAP_BEATS(1), .PREAMBLE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .datagram(dg[1][9:0]), .send_req(req[1]), .send_ack(ack[1]),
        .busy(busy[1]), .tx_sclk(sclk[1]), .tx_frame(frame[1]), .tx_data(data[1]),
        .drop_count(drop[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cd_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Reference frame: preamble, left-aligned payload, CRC-8/0x07 over the 12 payload bits
    function automatic logic [27:0] model_frame(input int d, input logic [11:0] v);
        logic [11:0] pay;
        logic [7:0]  crc;
        logic        fb;
        pay = (d == 0) ? v : {v[9:0], 2'b00};
        crc = 8'h00;
        for (int i = 11; i >= 0; i--) begin
            fb  = crc[7] ^ pay[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return {8'hA5, pay, crc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic qpush(input int d, input logic [27:0] f);
        if (d == 0) q0.push_back(f);
        else        q1.push_back(f);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [27:0] qpop(input int d);
        if (d == 0) return q0.pop_front();
        else        return q1.pop_front();
    endfunction

    // Reassemble frames as a receiver would and compare against the scoreboard
    task automatic monitor(input int d);
        logic [63:0] rx;
        logic [27:0] expv;
        int          nbeats, fcyc, gcyc;
        bit          in_frame, in_gap, gap_dirty, prev_sclk;
        rx = 64'd0; nbeats = 0; fcyc = 0; gcyc = 0;
        in_frame = 1'b0; in_gap = 1'b0; gap_dirty = 1'b0; prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 1'b0;
                in_gap    = 1'b0;
                prev_sclk = 1'b0;
            end else begin
                if (frame[d]) begin
                    if (!in_frame) begin
                        in_frame = 1'b1; in_gap = 1'b0; rx = 64'd0; nbeats = 0; fcyc = 0;
                    end
                    fcyc++;
                    if (sclk[d] && !prev_sclk) begin
                        rx = {rx[59:0], data[d]};
                        nbeats++;
                    end
                end else if (in_frame) begin
                    in_frame = 1'b0;
                    if (qsize(d) == 0) begin
                        checks++; errors++;
                        $display("FAIL dut%0d unexpected_frame: actual %0h required no frame", d, rx);
                    end else begin
                        expv = qpop(d);
                        check($sformatf("dut%0d frame_content", d), rx, {36'd0, expv});
                        check($sformatf("dut%0d frame_beats", d), 64'(nbeats), 64'd7);
                        check($sformatf("dut%0d frame_cycles", d), 64'(fcyc), 64'(7 * cd_of(d)));
                    end
                    in_gap = 1'b1; gcyc = 0; gap_dirty = 1'b0;
                end
                if (in_gap) begin
                    if (busy[d]) begin
                        gcyc++;
                        if ((data[d] != 4'h0) || frame[d]) gap_dirty = 1'b1;
                    end else begin
                        in_gap = 1'b0;
                        check($sformatf("dut%0d gap_cycles", d), 64'(gcyc), 64'(gap_of(d) * cd_of(d)));
                        check($sformatf("dut%0d gap_quiet", d), 64'(gap_dirty), 64'd0);
                    end
                end
                prev_sclk = sclk[d];
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy[d] && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        if (busy[d]) begin
            checks++; errors++;
            $display("FAIL dut%0d wait_idle: busy still %0b after %0d cycles, required 0", d, busy[d], n);
        end
    endtask

    // One accepted frame, optional datagram change after ack, then overrun pulses
    task automatic send(input int d, input logic [11:0] v, input int pulses, input bit change);
        @(posedge clk); #1;
        dg[d]  = v;
        req[d] = 1'b1;
        @(negedge clk);
        check($sformatf("dut%0d ack_in_req_cycle", d), 64'(ack[d]), 64'd1);
        qpush(d, model_frame(d, v));
        @(posedge clk); #1;
        req[d] = 1'b0;
        if (change) dg[d] = ~v;
        @(negedge clk);
        check($sformatf("dut%0d first_beat", d), {61'd0, ack[d], busy[d], frame[d]}, 64'd3);
        check($sformatf("dut%0d first_data", d), 64'(data[d]), 64'hA);
        for (int p = 0; p < pulses; p++) begin
            @(posedge clk); #1; req[d] = 1'b1;
            @(posedge clk); #1; req[d] = 1'b0;
        end
        drop_exp[d] = (drop_exp[d] + pulses > 255) ? 255 : drop_exp[d] + pulses;
        wait_idle(d);
        check($sformatf("dut%0d drop_count", d), 64'(drop[d]), 64'(drop_exp[d]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "time limit");
    end

    initial begin
        int          n;
        logic [31:0] r;
        checks = 0; errors = 0;
        drop_exp[0] = 0; drop_exp[1] = 0;
        rst = 1'b1; req = 2'b00; dg[0] = 12'h000; dg[1] = 12'h000;

        // Reset state, and reset beating a simultaneous request
        repeat (3) @(posedge clk);
        #1 req[0] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset_flags", d),
                  {60'd0, ack[d], busy[d], sclk[d], frame[d]}, 64'd0);
            check($sformatf("dut%0d reset_data_drop", d), {52'd0, data[d], drop[d]}, 64'd0);
        end
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("dut0 no_frame_after_rst_req", {62'd0, busy[0], frame[0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frame, all-zero payload, padding case
        send(0, 12'hABC, 0, 1'b0);
        send(0, 12'h000, 0, 1'b0);
        send(1, 12'h3FF, 0, 1'b0);
        // Snapshot: datagram changes the cycle after ack
        send(0, 12'h5A3, 0, 1'b1);
        send(1, 12'h1C7, 0, 1'b1);

        // Overrun: three lost requests, no extra frame
        send(0, 12'h123, 3, 1'b0);
        // Saturation beyond 255 drops
        for (int i = 0; i < 38; i++) begin
            r = $urandom;
            send(0, r[11:0], 8, 1'b0);
        end

        // Request held high: back-to-back frames separated only by the gap
        @(posedge clk); #1;
        dg[1]  = 12'h2E1;
        req[1] = 1'b1;
        @(negedge clk);
        check("dut1 b2b_first_ack", 64'(ack[1]), 64'd1);
        qpush(1, model_frame(1, 12'h2E1));
        qpush(1, model_frame(1, 12'h2E1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[1] && (n < 100));
        check("dut1 b2b_ack_interval", 64'(n), 64'd33);
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_idle(1);
        check("dut1 b2b_drop_count", 64'(drop[1]), 64'(drop_exp[1]));

        // Mid-payload reset, then a clean restart
        @(posedge clk); #1;
        dg[0]  = 12'hF0F;
        req[0] = 1'b1;
        @(negedge clk);
        check("dut0 pre_rst_ack", 64'(ack[0]), 64'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        drop_exp[0] = 0; drop_exp[1] = 0;
        check("dut0 mid_rst_outputs", {60'd0, busy[0], sclk[0], frame[0], ack[0]}, 64'd0);
        check("dut0 mid_rst_drop", 64'(drop[0]), 64'd0);
        check("dut0 mid_rst_data", 64'(data[0]), 64'd0);
        repeat (3) @(posedge clk);
        send(0, 12'h9D2, 0, 1'b0);

        // Randomized traffic on both instances
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            send(int'(r[31]), r[11:0], int'($urandom_range(0, 4)), r[30]);
        end

        repeat (10) @(negedge clk);
        check("dut0 scoreboard_empty", 64'(q0.size()), 64'd0);
        check("dut1 scoreboard_empty", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
